// File: rtl/tdp_ram_be.sv
// True dual-port RAM with byte enables, a zero-fill sweep after reset, configurable
// read-during-write behaviour and optional output register.
module tdp_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_a,
  input  logic [DATA_WIDTH/8-1:0] we_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   din_a,
  output logic [DATA_WIDTH-1:0]   dout_a,
  output logic                    rvalid_a,
  input  logic                    en_b,
  input  logic [DATA_WIDTH/8-1:0] we_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   din_b,
  output logic [DATA_WIDTH-1:0]   dout_b,
  output logic                    rvalid_b,
  output logic                    init_done,
  output logic                    collision,
  output logic [15:0]             coll_count
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_initDone;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_p1ValA, r_p1ValB;
  logic [DATA_WIDTH-1:0] r_p1DataA, r_p1DataB;
  logic                  r_rvalidA, r_rvalidB;
  logic [DATA_WIDTH-1:0] r_doutA, r_doutB;
  logic                  r_collision;
  logic [15:0]           r_collCount;

  logic                  w_accA, w_accB;
  logic                  w_clash;
  logic                  w_sweep;
  logic                  w_wrA, w_wrB;
  logic [DATA_WIDTH-1:0] w_oldA, w_oldB;
  logic [DATA_WIDTH-1:0] w_mergeA, w_mergeB;
  logic [DATA_WIDTH-1:0] w_clashWord;
  logic [DATA_WIDTH-1:0] w_wordA;
  logic [DATA_WIDTH-1:0] w_rdA, w_rdB;

  assign w_accA  = en_a && r_initDone && !rst;
  assign w_accB  = en_b && r_initDone && !rst;
  assign w_sweep = (r_state == ST_INIT) && !rst;
  assign w_clash = w_accA && w_accB && (addr_a == addr_b) && (|we_a) && (|we_b);

  assign w_oldA = r_mem[addr_a];
  assign w_oldB = r_mem[addr_b];

  always_comb begin
    w_mergeA    = w_oldA;
    w_mergeB    = w_oldB;
    for (int k = 0; k < NB; k++) begin
      if (we_a[k]) w_mergeA[8*k +: 8] = din_a[8*k +: 8];
      if (we_b[k]) w_mergeB[8*k +: 8] = din_b[8*k +: 8];
    end
    // On a clash port A's merged word absorbs B's bytes wherever A left a gap
    w_clashWord = w_mergeA;
    for (int k = 0; k < NB; k++) begin
      if (we_b[k] && !we_a[k]) w_clashWord[8*k +: 8] = din_b[8*k +: 8];
    end
  end

  assign w_wrA   = w_accA && (|we_a);
  assign w_wrB   = w_accB && (|we_b) && !w_clash;
  assign w_wordA = w_clash ? w_clashWord : w_mergeA;
  assign w_rdA   = (RDW_MODE != 0) ? w_mergeA : w_oldA;
  assign w_rdB   = (RDW_MODE != 0) ? w_mergeB : w_oldB;

  always_ff @(posedge clk) begin
    if (w_sweep) r_mem[r_ptr] <= '0;
    if (w_wrA)   r_mem[addr_a] <= w_wordA;
    if (w_wrB)   r_mem[addr_b] <= w_mergeB;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_ptr      <= '0;
      r_initDone <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_ptr <= r_ptr + 1'b1;
      if (r_ptr == '1) begin
        r_state    <= ST_RUN;
        r_initDone <= 1'b1;
      end
    end
  end

  // Output data registers only load on a valid beat so dout holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1ValA    <= 1'b0;
      r_p1ValB    <= 1'b0;
      r_p1DataA   <= '0;
      r_p1DataB   <= '0;
      r_rvalidA   <= 1'b0;
      r_rvalidB   <= 1'b0;
      r_doutA     <= '0;
      r_doutB     <= '0;
      r_collision <= 1'b0;
      r_collCount <= '0;
    end else begin
      r_collision <= w_clash;
      if (w_clash && (r_collCount != 16'hFFFF)) r_collCount <= r_collCount + 1'b1;
      if (OUT_REG != 0) begin
        r_p1ValA  <= w_accA;
        r_p1ValB  <= w_accB;
        if (w_accA) r_p1DataA <= w_rdA;
        if (w_accB) r_p1DataB <= w_rdB;
        r_rvalidA <= r_p1ValA;
        r_rvalidB <= r_p1ValB;
        if (r_p1ValA) r_doutA <= r_p1DataA;
        if (r_p1ValB) r_doutB <= r_p1DataB;
      end else begin
        r_rvalidA <= w_accA;
        r_rvalidB <= w_accB;
        if (w_accA) r_doutA <= w_rdA;
        if (w_accB) r_doutB <= w_rdB;
      end
    end
  end

  assign dout_a     = r_doutA;
  assign dout_b     = r_doutB;
  assign rvalid_a   = r_rvalidA;
  assign rvalid_b   = r_rvalidB;
  assign init_done  = r_initDone;
  assign collision  = r_collision;
  assign coll_count = r_collCount;

endmodule

// File: tb/tb_tdp_ram_be.sv
// Directed bench for tdp_ram_be: drives one default instance (read-first, LAT=1) and one
// write-first instance with an output register (LAT=2) from the same stimulus.
module tb_tdp_ram_be;

  logic        clk;
  logic        rst;
  logic        enA, enB;
  logic [3:0]  weA, weB;
  logic [5:0]  addrA, addrB;
  logic [31:0] dinA, dinB;

  logic [31:0] doutA0, doutB0, doutA1, doutB1;
  logic        rvalidA0, rvalidB0, rvalidA1, rvalidB1;
  logic        initDone0, initDone1;
  logic        collision0, collision1;
  logic [15:0] collCount0, collCount1;

  int nTests = 0;
  int nFail  = 0;

  tdp_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .RDW_MODE(0), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst),
    .en_a(enA), .we_a(weA), .addr_a(addrA), .din_a(dinA), .dout_a(doutA0), .rvalid_a(rvalidA0),
    .en_b(enB), .we_b(weB), .addr_b(addrB), .din_b(dinB), .dout_b(doutB0), .rvalid_b(rvalidB0),
    .init_done(initDone0), .collision(collision0), .coll_count(collCount0)
  );

  tdp_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .RDW_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst),
    .en_a(enA), .we_a(weA), .addr_a(addrA), .din_a(dinA), .dout_a(doutA1), .rvalid_a(rvalidA1),
    .en_b(enB), .we_b(weB), .addr_b(addrB), .din_b(dinB), .dout_b(doutB1), .rvalid_b(rvalidB1),
    .init_done(initDone1), .collision(collision1), .coll_count(collCount1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enA = 1'b0; weA = '0; addrA = '0; dinA = '0;
    enB = 1'b0; weB = '0; addrB = '0; dinB = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests on both ports, let the edge capture them, then go idle
  task automatic applyStimulus(input logic ea, input logic [3:0] wa, input logic [5:0] aa,
                               input logic [31:0] da, input logic eb, input logic [3:0] wb,
                               input logic [5:0] ab, input logic [31:0] db);
    enA = ea; weA = wa; addrA = aa; dinA = da;
    enB = eb; weB = wb; addrB = ab; dinB = db;
    tick();
    idle();
  endtask

  task automatic readCheck(input string tag, input logic isB, input logic [5:0] addr,
                           input logic [31:0] exp);
    if (isB) applyStimulus(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'h0, addr, 32'h0);
    else     applyStimulus(1'b1, 4'h0, addr, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    checkOutput({tag, "/lat1Valid"}, isB ? rvalidB0 : rvalidA0, 32'd1);
    checkOutput({tag, "/lat1Data"},  isB ? doutB0 : doutA0, exp);
    checkOutput({tag, "/lat2Early"}, isB ? rvalidB1 : rvalidA1, 32'd0);
    tick();
    checkOutput({tag, "/lat2Valid"}, isB ? rvalidB1 : rvalidA1, 32'd1);
    checkOutput({tag, "/lat2Data"},  isB ? doutB1 : doutA1, exp);
    checkOutput({tag, "/lat1Drop"},  isB ? rvalidB0 : rvalidA0, 32'd0);
    checkOutput({tag, "/lat1Hold"},  isB ? doutB0 : doutA0, exp);
  endtask

  // Count cycles until init_done while poking both ports during the early sweep
  task automatic waitInit(input string tag);
    int   cnt;
    logic sawValid;
    cnt      = 0;
    sawValid = 1'b0;
    while (initDone0 !== 1'b1 && cnt < 200) begin
      if (cnt < 10) begin
        enA = 1'b1; weA = 4'hF; addrA = 6'd7; dinA = 32'hDEADBEEF;
        enB = 1'b1; weB = 4'h0; addrB = 6'd7; dinB = 32'h0;
      end else begin
        idle();
      end
      tick();
      cnt++;
      if (rvalidA0 === 1'b1 || rvalidB0 === 1'b1 || rvalidA1 === 1'b1 || rvalidB1 === 1'b1)
        sawValid = 1'b1;
    end
    idle();
    checkOutput({tag, "/sweepCycles"}, cnt, 32'd64);
    checkOutput({tag, "/initDone1"}, initDone1, 32'd1);
    checkOutput({tag, "/noRvalidInSweep"}, sawValid, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    checkOutput("reset/doutA0", doutA0, 32'h0);
    checkOutput("reset/rvalidA0", rvalidA0, 32'd0);
    checkOutput("reset/initDone0", initDone0, 32'd0);
    checkOutput("reset/collCount0", collCount0, 32'd0);
    checkOutput("reset/collision0", collision0, 32'd0);
    checkOutput("reset/doutB1", doutB1, 32'h0);

    rst = 1'b0;
    waitInit("init");
    for (int i = 0; i < 64; i++) begin
      logic [5:0] a;
      a = 6'(i);
      readCheck($sformatf("scan%0d", i), a[0], a, 32'h0);
    end

    applyStimulus(1'b1, 4'hF, 6'd5, 32'hDDCCBBAA, 1'b0, 4'h0, 6'd0, 32'h0);
    tick();
    applyStimulus(1'b1, 4'b0101, 6'd5, 32'h11223344, 1'b0, 4'h0, 6'd0, 32'h0);
    tick();
    readCheck("byteEnA", 1'b0, 6'd5, 32'hDD22BB44);

    applyStimulus(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'b1010, 6'd12, 32'hA1B2C3D4);
    tick();
    readCheck("byteEnB", 1'b0, 6'd12, 32'hA100C300);

    applyStimulus(1'b1, 4'hF, 6'd3, 32'h1, 1'b0, 4'h0, 6'd0, 32'h0);
    tick();
    applyStimulus(1'b1, 4'hF, 6'd3, 32'h2, 1'b1, 4'h0, 6'd3, 32'h0);
    checkOutput("rdw/rvalidA0", rvalidA0, 32'd1);
    checkOutput("rdw/readFirstA0", doutA0, 32'h1);
    checkOutput("rdw/crossB0", doutB0, 32'h1);
    tick();
    checkOutput("rdw/rvalidA1", rvalidA1, 32'd1);
    checkOutput("rdw/writeFirstA1", doutA1, 32'h2);
    checkOutput("rdw/crossB1", doutB1, 32'h1);
    readCheck("rdw/after", 1'b1, 6'd3, 32'h2);

    applyStimulus(1'b1, 4'hF, 6'd20, 32'h12345678, 1'b1, 4'hF, 6'd21, 32'h9ABCDEF0);
    checkOutput("indep/noCollision", collision0, 32'd0);
    tick();
    applyStimulus(1'b1, 4'h0, 6'd21, 32'h0, 1'b1, 4'h0, 6'd20, 32'h0);
    checkOutput("indep/doutA0", doutA0, 32'h9ABCDEF0);
    checkOutput("indep/doutB0", doutB0, 32'h12345678);
    tick();
    checkOutput("indep/doutA1", doutA1, 32'h9ABCDEF0);
    checkOutput("indep/doutB1", doutB1, 32'h12345678);

    applyStimulus(1'b1, 4'b0011, 6'd9, 32'hAAAAAAAA, 1'b1, 4'hF, 6'd9, 32'hBBBBBBBB);
    checkOutput("clash/collision0", collision0, 32'd1);
    checkOutput("clash/collision1", collision1, 32'd1);
    checkOutput("clash/count0", collCount0, 32'd1);
    tick();
    checkOutput("clash/pulseEnds", collision0, 32'd0);
    checkOutput("clash/countHolds", collCount0, 32'd1);
    readCheck("clash/word", 1'b1, 6'd9, 32'hBBBBAAAA);

    applyStimulus(1'b1, 4'hF, 6'd9, 32'hCAFEF00D, 1'b1, 4'h0, 6'd9, 32'h0);
    checkOutput("cross/oldWordB0", doutB0, 32'hBBBBAAAA);
    checkOutput("cross/noCollision", collision0, 32'd0);
    checkOutput("cross/countSame", collCount0, 32'd1);
    tick();
    readCheck("cross/after", 1'b1, 6'd9, 32'hCAFEF00D);

    enA = 1'b1; weA = 4'h1; addrA = 6'd40; dinA = 32'h0;
    enB = 1'b1; weB = 4'h1; addrB = 6'd40; dinB = 32'h0;
    repeat (65533) tick();
    checkOutput("sat/count65534", collCount0, 32'hFFFE);
    repeat (3) tick();
    checkOutput("sat/holds0", collCount0, 32'hFFFF);
    checkOutput("sat/holds1", collCount1, 32'hFFFF);
    idle();
    tick();

    enA = 1'b1; weA = 4'h0; addrA = 6'd5;
    enB = 1'b1; weB = 4'h0; addrB = 6'd12;
    tick();
    rst = 1'b1;
    idle();
    tick();
    checkOutput("midRst/rvalidA0", rvalidA0, 32'd0);
    checkOutput("midRst/doutA0", doutA0, 32'h0);
    checkOutput("midRst/doutB0", doutB0, 32'h0);
    checkOutput("midRst/initDone0", initDone0, 32'd0);
    checkOutput("midRst/collCount0", collCount0, 32'd0);
    tick();
    checkOutput("midRst/noLateRvalidA1", rvalidA1, 32'd0);
    checkOutput("midRst/noLateRvalidB1", rvalidB1, 32'd0);
    checkOutput("midRst/doutB1", doutB1, 32'h0);
    rst = 1'b0;
    waitInit("reinit");
    readCheck("wiped20", 1'b0, 6'd20, 32'h0);
    readCheck("wiped5", 1'b1, 6'd5, 32'h0);
    readCheck("wiped9", 1'b0, 6'd9, 32'h0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/tdp_ram_be.md
TDP_RAM_BE -- requirements
Module: tdp_ram_be

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Parameter DATA_WIDTH SHALL default to 32 and set the word width; it SHALL be a multiple of 8.
REQ-003 Parameter ADDR_WIDTH SHALL default to 6 and set the depth to DEPTH = 2**ADDR_WIDTH.
REQ-004 Parameter RDW_MODE SHALL default to 0 and set same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data).
REQ-005 Parameter OUT_REG SHALL default to 0; 1 adds one output register stage, so read latency LAT = 1 + OUT_REG.
REQ-006 Ports, with NB = DATA_WIDTH/8 and x in {a,b}:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en_x  in  1  access request, port x
- we_x  in  NB  byte write enables, port x
- addr_x  in  ADDR_WIDTH  address, port x
- din_x  in  DATA_WIDTH  write data, port x
- dout_x  out  DATA_WIDTH  read data, port x
- rvalid_x  out  1  dout_x valid, port x
- init_done  out  1  clear sweep complete; accesses accepted
- collision  out  1  one-cycle pulse on a write-write address clash
- coll_count  out  16  saturating count of collisions

Function
REQ-007 The controller SHALL have two states, INIT and RUN; rst SHALL force INIT with sweep pointer 0.
REQ-008 In INIT, the controller SHALL write zero to address ptr once per cycle and increment ptr; after writing DEPTH-1 it SHALL enter RUN, and init_done SHALL be 1 from the next cycle. The sweep SHALL take exactly DEPTH cycles.
REQ-009 While init_done=0, all en_x SHALL be ignored: no write, no rvalid_x.
REQ-010 In RUN, an access is accepted when en_x=1. Each set bit k of we_x SHALL write din_x[8k+7:8k] to byte k of word addr_x; clear bits SHALL leave that byte unchanged.
REQ-011 Every accepted access, read or write, SHALL assert rvalid_x exactly LAT cycles later for one cycle, with dout_x holding the word at addr_x.
REQ-012 Same-port write with read: dout_x SHALL be the pre-write word if RDW_MODE=0, or the post-write merged word if RDW_MODE=1.
REQ-013 Cross-port access to the same address in the same cycle SHALL always return the pre-write word to the reading port.
REQ-014 Write-write clash (both accepted, addr_a==addr_b, we_a!=0 and we_b!=0): for each byte, port A's data SHALL win where its we_a bit is set; port B's byte SHALL be written only where its we_a bit is 0 and its we_b bit is 1.
REQ-015 On a clash, collision SHALL pulse high in the following cycle, and coll_count SHALL increment by 1, saturating at 16'hFFFF.
REQ-016 When rvalid_x=0, dout_x SHALL hold its last value.
REQ-017 Ports A and B SHALL be fully independent when their addresses differ; both may access on every cycle, giving a throughput of 1 access/cycle/port.

Reset
REQ-018 On rst=1 at a clk edge: dout_a=dout_b=0, rvalid_a=rvalid_b=0, init_done=0, collision=0, coll_count=0, and all pipeline stages SHALL be cleared.
REQ-019 A reset asserted mid-sweep or mid-read SHALL discard in-flight reads (no rvalid) and restart the sweep at address 0 when rst deasserts.
REQ-020 Memory contents SHALL be all-zero once init_done rises after any reset.

Verification
REQ-021 Init: release rst, ADDR_WIDTH=6 -> init_done rises after 64 cycles; reading all 64 addresses returns 0; en_a pulsed during sweep gives no rvalid_a.
REQ-022 Byte enables: write 0xDDCCBBAA with we=4'hF, then 0x11223344 with we=4'b0101 to address 5; read -> 0xDD22BB44, rvalid after LAT cycles (run with OUT_REG=0 and OUT_REG=1).
REQ-023 RDW: address 3 holds 0x1; write 0x2 with read on the same port -> dout=0x1 (RDW_MODE=0) or 0x2 (RDW_MODE=1); port B reading address 3 in the same cycle -> 0x1.
REQ-024 Clash: both ports write address 9 on one cycle, A 0xAAAAAAAA we=4'b0011, B 0xBBBBBBBB we=4'b1111 -> word 0xBBBBAAAA, collision pulses once, coll_count=1; force 65536 clashes -> coll_count holds 0xFFFF.
REQ-025 Reset mid-operation: issue reads on both ports, assert rst the next cycle -> no rvalid, outputs 0, a new 64-cycle sweep, and previously written data reads 0.
